ones_run_scheduler: RTL and testbench

Shares one ones-count Mealy detector among `N_REQ` serial bit requesters. A round-robin arbiter grants one requester per cycle. Each channel's detector state is saved and restored per grant, so every channel behaves as if it owned a private detector. Hits are reported per event and accumulated in a saturating counter that also drives the board LEDs.

---
 rtl/ones_run_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/ones_run_scheduler.sv | 105 ++++++++++
 tb/tb_ones_run_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ones_run_pkg.sv
// Shared constants, detector step result type and the ones-count step function
// for the ones_run_scheduler block.
package ones_run_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int RUN_LEN_DEF = 4;
    localparam int CNT_W_DEF   = 8;

    // Wide enough for a count up to RUN_LEN-1 with RUN_LEN <= 8.
    localparam int ST_W = 3;

    typedef struct packed {
        logic [ST_W-1:0] next_st;
        logic            hit;
    } step_res_t;

    // Zeros hold the count except in the last state, where any bit closes the run.
    function automatic step_res_t ones_step(input logic [ST_W-1:0] st,
                                            input logic            b,
                                            input int              run_len);
        step_res_t res;
        res.next_st = st;
        res.hit     = 1'b0;
        if (int'(st) == run_len - 1) begin
            res.next_st = '0;
            res.hit     = b;
        end else if (b) begin
            res.next_st = st + ST_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester found scanning from ptr.
module rr_arbiter
    import ones_run_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] ptr,
    input  logic             clr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    // Scan farthest-to-nearest so the candidate closest to ptr wins last.
    always_comb begin
        int j;
        j         = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req_valid[j] && !clr) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
        assign grant[gi] = grant_any && (grant_idx == IDX_W'(gi));
    end

endmodule

// File: rtl/ones_run_scheduler.sv
// Time-shared ones-count detector: one step function serves N_REQ serial channels,
// each with its own saved count, plus a saturating hit counter driving the LEDs.
module ones_run_scheduler
    import ones_run_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int RUN_LEN = RUN_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_bit,
    output logic [N_REQ-1:0] req_ready,
    output logic             hit_valid,
    output logic [IDX_W-1:0] hit_chan,
    output logic [CNT_W-1:0] total_hits,
    output logic [3:0]       led
);

    localparam logic [CNT_W-1:0] TOTAL_MAX = '1;

    logic [N_REQ-1:0][ST_W-1:0] st_q, st_d;
    logic [IDX_W-1:0]           ptr_q, ptr_d;
    logic                       hit_valid_q, hit_valid_d;
    logic [IDX_W-1:0]           hit_chan_q, hit_chan_d;
    logic [CNT_W-1:0]           total_q, total_d;
    logic [3:0]                 led_q, led_d;

    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             block_grant;
    step_res_t        step_res;

    // Reset behaves like clr, so no grant is offered while it is asserted.
    assign block_grant = clr | ~reset;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .clr       (block_grant),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;
    assign step_res  = ones_step(st_q[grant_idx], req_bit[grant_idx], RUN_LEN);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_state
        assign st_d[gi] = clr ? '0 :
                          (grant_any && grant_idx == IDX_W'(gi)) ? step_res.next_st :
                          st_q[gi];
    end

    always_comb begin
        ptr_d       = ptr_q;
        hit_valid_d = 1'b0;
        hit_chan_d  = hit_chan_q;
        total_d     = total_q;
        led_d       = 4'(total_q);
        if (clr) begin
            ptr_d      = '0;
            hit_chan_d = '0;
            total_d    = '0;
            led_d      = '0;
        end else if (grant_any) begin
            ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            if (step_res.hit) begin
                hit_valid_d = 1'b1;
                hit_chan_d  = grant_idx;
                if (total_q != TOTAL_MAX) begin
                    total_d = total_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q        <= '0;
            ptr_q       <= '0;
            hit_valid_q <= 1'b0;
            hit_chan_q  <= '0;
            total_q     <= '0;
            led_q       <= '0;
        end else begin
            st_q        <= st_d;
            ptr_q       <= ptr_d;
            hit_valid_q <= hit_valid_d;
            hit_chan_q  <= hit_chan_d;
            total_q     <= total_d;
            led_q       <= led_d;
        end
    end

    assign hit_valid  = hit_valid_q;
    assign hit_chan   = hit_chan_q;
    assign total_hits = total_q;
    assign led        = led_q;

endmodule

// File: tb/tb_ones_run_scheduler.sv
// Randomised and directed bench for ones_run_scheduler against a per-channel run-count model.
module tb_ones_run_scheduler;

    localparam int NR   = 4;
    localparam int RL   = 4;
    localparam int CW   = 3;
    localparam int TMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clr = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_bit = '0;
    logic [NR-1:0] req_ready;
    logic          hit_valid;
    logic [1:0]    hit_chan;
    logic [CW-1:0] total_hits;
    logic [3:0]    led;

    ones_run_scheduler #(.N_REQ(NR), .RUN_LEN(RL), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_bit    (req_bit),
        .req_ready  (req_ready),
        .hit_valid  (hit_valid),
        .hit_chan   (hit_chan),
        .total_hits (total_hits),
        .led        (led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int q0[$], q1[$], q2[$], q3[$];
    bit hold[NR];
    int hit_log[$];
    int grant_log[$];

    // Model: per-channel run count, pointer, expected registered outputs.
    int  m_cnt[NR];
    int  m_ptr;
    bit  m_valid = 0;
    int  e_hv, e_chan, e_total, e_led;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic int qhead(input int i);
        case (i)
            0: return q0[0];
            1: return q1[0];
            2: return q2[0];
            default: return q3[0];
        endcase
    endfunction

    task automatic qpop(input int i);
        case (i)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            default: void'(q3.pop_front());
        endcase
    endtask

    task automatic qpush(input int i, input int b);
        case (i)
            0: q0.push_back(b);
            1: q1.push_back(b);
            2: q2.push_back(b);
            default: q3.push_back(b);
        endcase
    endtask

    function automatic int pending();
        return q0.size() + q1.size() + q2.size() + q3.size();
    endfunction

    // One clock: entered and left at a falling edge.
    task automatic step_cycle(input bit rst_n, input bit clr_i, input int pct);
        int g;
        int b;
        bit hit;
        if (m_valid) begin
            if (hit_valid) hit_log.push_back(int'(hit_chan));
            chk("hit_valid", int'(hit_valid), e_hv);
            chk("hit_chan", int'(hit_chan), e_chan);
            chk("total_hits", int'(total_hits), e_total);
            chk("led", int'(led), e_led);
        end
        reset = rst_n;
        clr   = clr_i;
        for (int i = 0; i < NR; i++) begin
            if (qsize(i) > 0 && (hold[i] || int'($urandom_range(99)) < pct)) begin
                req_valid[i] = 1'b1;
                req_bit[i]   = qhead(i)[0];
            end else begin
                req_valid[i] = 1'b0;
                req_bit[i]   = 1'($urandom_range(1));
            end
        end
        #1;
        g = -1;
        if (rst_n && !clr_i) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            end
        end
        chk("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
        @(posedge clk);
        if (!rst_n || clr_i) begin
            for (int i = 0; i < NR; i++) m_cnt[i] = 0;
            m_ptr = 0; e_hv = 0; e_chan = 0; e_total = 0; e_led = 0;
        end else begin
            e_led = e_total % 16;
            e_hv  = 0;
            if (g >= 0) begin
                b   = int'(req_bit[g]);
                hit = 0;
                if (m_cnt[g] == RL - 1) begin
                    hit      = (b == 1);
                    m_cnt[g] = 0;
                end else if (b == 1) begin
                    m_cnt[g]++;
                end
                m_ptr = (g + 1) % NR;
                if (hit) begin
                    e_hv   = 1;
                    e_chan = g;
                    if (e_total < TMAX) e_total++;
                end
            end
        end
        for (int i = 0; i < NR; i++) hold[i] = req_valid[i] && (g != i);
        if (g >= 0) begin
            qpop(g);
            grant_log.push_back(g);
        end
        m_valid = 1;
        @(negedge clk);
    endtask

    task automatic drain(input int pct);
        int n;
        n = 0;
        while (pending() > 0 && n < 300) begin
            step_cycle(1, 0, pct);
            n++;
        end
        chk("drain_timeout", pending(), 0);
        step_cycle(1, 0, pct);
        step_cycle(1, 0, pct);
    endtask

    task automatic do_clr();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        step_cycle(1, 1, 0);
        for (int i = 0; i < NR; i++) hold[i] = 0;
        hit_log.delete();
        grant_log.delete();
    endtask

    initial begin
        int exp_f1[8];
        int exp_f2[6];
        int r;
        exp_f1 = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_f2 = '{0, 1, 3, 0, 1, 3};
        @(negedge clk);

        // Reset held with every requester valid: no grants, outputs zero.
        for (int i = 0; i < NR; i++) qpush(i, 1);
        for (int c = 0; c < 3; c++) step_cycle(0, 0, 100);
        chk("rst_hit_valid", int'(hit_valid), 0);
        chk("rst_total", int'(total_hits), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_grants", grant_log.size(), 0);
        step_cycle(1, 0, 100);
        chk("rst_first_grant", grant_log[0], 0);
        do_clr();

        // Single channel 1,0,1,1,1 -> one hit on ch1.
        q1 = '{1, 0, 1, 1, 1};
        drain(100);
        chk("single_hits", hit_log.size(), 1);
        if (hit_log.size() > 0) chk("single_chan", hit_log[0], 1);
        chk("single_total", int'(total_hits), 1);
        chk("single_led", int'(led), 1);
        do_clr();

        // Zero in the last state restarts the run.
        q0 = '{1, 1, 1, 0, 1, 1, 1, 1};
        drain(100);
        chk("lastzero_hits", hit_log.size(), 1);
        chk("lastzero_total", int'(total_hits), 1);
        do_clr();

        // Fairness with all four valid, then with ch2 withdrawn.
        for (int i = 0; i < NR; i++) for (int k = 0; k < 30; k++) qpush(i, 0);
        for (int c = 0; c < 8; c++) step_cycle(1, 0, 100);
        for (int i = 0; i < 8; i++) chk($sformatf("fair_a%0d", i), grant_log[i], exp_f1[i]);
        q2.delete();
        grant_log.delete();
        for (int c = 0; c < 6; c++) step_cycle(1, 0, 100);
        for (int i = 0; i < 6; i++) chk($sformatf("fair_b%0d", i), grant_log[i], exp_f2[i]);
        do_clr();

        // Interleaved channels keep separate counts.
        q0 = '{1, 1, 1, 1};
        q3 = '{1, 1, 1, 1};
        drain(100);
        chk("inter_hits", hit_log.size(), 2);
        if (hit_log.size() == 2) begin
            chk("inter_chan0", hit_log[0], 0);
            chk("inter_chan1", hit_log[1], 3);
        end
        chk("inter_total", int'(total_hits), 2);
        do_clr();

        // Saturation at 7 with 9 hits, then clr discards a partial count.
        for (int k = 0; k < 9 * RL; k++) qpush(2, 1);
        drain(100);
        chk("sat_hits", hit_log.size(), 9);
        chk("sat_total", int'(total_hits), TMAX);
        q1 = '{1, 1};
        drain(100);
        do_clr();
        chk("clr_total", int'(total_hits), 0);
        q1 = '{1, 1, 1};
        drain(100);
        chk("clr_partial_nohit", hit_log.size(), 0);
        q1 = '{1};
        drain(100);
        chk("clr_full_hit", hit_log.size(), 1);
        chk("clr_total_after", int'(total_hits), 1);
        do_clr();

        // Random traffic with occasional clr and reset.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (qsize(i) < 2) qpush(i, ($urandom_range(99) < 75) ? 1 : 0);
            end
            r = int'($urandom_range(199));
            step_cycle(r != 0, (r > 0 && r < 4), 50);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
